// File: rtl/coin_accumulator.sv
// -----------------------------------------------------------------------------
// coin_accumulator
//   Upstream credit stage for the beverage dispenser. Detects coin insertions,
//   accumulates credit, presents it on moneyin, deducts the cost of each vended
//   beverage and returns the remainder as change. A cancel request refunds the
//   full credit.
//
//   Optional build macro: COIN_AUDIT_EN
//     When defined, adds audit_revenue / audit_vends counters that track the
//     total amount actually deducted and the number of vends (both saturate).
// -----------------------------------------------------------------------------
module coin_accumulator #(
   parameter logic [9:0] BEV1_COST   = 10'd125,
   parameter logic [9:0] BEV2_COST   = 10'd220,
   parameter logic [9:0] BEV3_COST   = 10'd175,
   parameter logic [9:0] MAX_CREDIT  = 10'd500,
   parameter logic [9:0] NICKEL_VAL  = 10'd5,
   parameter logic [9:0] DIME_VAL    = 10'd10,
   parameter logic [9:0] QUARTER_VAL = 10'd25,
   parameter logic [9:0] DOLLAR_VAL  = 10'd100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_nickel,
   input  logic       coin_dime,
   input  logic       coin_quarter,
   input  logic       coin_dollar,
   input  logic       cancel,
   input  logic       outbev1,
   input  logic       outbev2,
   input  logic       outbev3,
   output logic [9:0] moneyin,
   output logic [9:0] change_out,
   output logic       change_valid,
   output logic       coin_reject
`ifdef COIN_AUDIT_EN
   ,
   output logic [15:0] audit_revenue,
   output logic [7:0]  audit_vends
`endif
);

   // ACCUM collects coins and waits for a vend/cancel; CHANGE is a single
   // cycle that pays out whatever credit is left and clears it.
   typedef enum logic {
      ACCUM  = 1'b0,
      CHANGE = 1'b1
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   logic [9:0]  credit_reg;
   logic [9:0]  credit_next;
   logic [9:0]  moneyin_reg;
   logic [9:0]  moneyin_next;
   logic [9:0]  change_out_reg;
   logic [9:0]  change_out_next;
   logic        change_valid_reg;
   logic        change_valid_next;
   logic        coin_reject_reg;
   logic        coin_reject_next;

   // Coin vector ordering: bit 0 nickel, 1 dime, 2 quarter, 3 dollar.
   logic [3:0]  coin_lvl;
   logic [3:0]  coin_prev_reg;
   logic [3:0]  coin_rise;
   logic        first_reg;
   logic        any_rise;
   logic        multi_rise;

   logic        vend;
   logic [9:0]  vend_cost;
   logic [9:0]  vend_deduct;
   logic [9:0]  coin_val;
   logic [10:0] coin_sum;
   logic        coin_fits;

   assign coin_lvl = {coin_dollar, coin_quarter, coin_dime, coin_nickel};

   // A rise needs the current level high and the previous level low. On the
   // first cycle out of reset the previous level is not yet meaningful, so a
   // coin that was already high at that point is masked instead of counted.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rise
         assign coin_rise[gi] = coin_lvl[gi] & ~coin_prev_reg[gi] & ~first_reg;
      end
   endgenerate

   assign any_rise   = |coin_rise;
   // More than one bit set: clearing the lowest set bit leaves something.
   assign multi_rise = |(coin_rise & (coin_rise - 4'd1));

   assign vend = outbev1 | outbev2 | outbev3;

   // Vend cost selection, same priority as the dispenser (1 > 2 > 3).
   always_comb begin
      vend_cost = 10'd0;
      if (outbev1) begin
         vend_cost = BEV1_COST;
      end else if (outbev2) begin
         vend_cost = BEV2_COST;
      end else if (outbev3) begin
         vend_cost = BEV3_COST;
      end
   end

   // Deduction saturates: never take more than the credit actually held.
   assign vend_deduct = (credit_reg >= vend_cost) ? vend_cost : credit_reg;

   // Highest-value rising coin is the one considered for acceptance.
   always_comb begin
      coin_val = 10'd0;
      if (coin_rise[3]) begin
         coin_val = DOLLAR_VAL;
      end else if (coin_rise[2]) begin
         coin_val = QUARTER_VAL;
      end else if (coin_rise[1]) begin
         coin_val = DIME_VAL;
      end else if (coin_rise[0]) begin
         coin_val = NICKEL_VAL;
      end
   end

   // One extra bit on the sum so the limit compare cannot be fooled by wrap.
   assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_val};
   assign coin_fits = (coin_sum <= {1'b0, MAX_CREDIT});

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ACCUM;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: vend or a non-empty cancel moves to CHANGE, CHANGE
   // always returns to ACCUM after one cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ACCUM: begin
            if (vend || (cancel && (credit_reg != 10'd0))) begin
               state_next = CHANGE;
            end
         end
         CHANGE: begin
            state_next = ACCUM;
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // Output and credit datapath logic for the current state.
   always_comb begin
      credit_next       = credit_reg;
      change_out_next   = change_out_reg;
      change_valid_next = 1'b0;
      coin_reject_next  = 1'b0;
      case (state_reg)
         ACCUM: begin
            if (vend) begin
               // Coins arriving alongside a vend are handed back untouched.
               credit_next      = credit_reg - vend_deduct;
               coin_reject_next = any_rise;
            end else if (cancel && (credit_reg != 10'd0)) begin
               // Full refund: credit is kept and paid out in CHANGE.
               coin_reject_next = any_rise;
            end else if (any_rise) begin
               if (coin_fits) begin
                  credit_next      = coin_sum[9:0];
                  coin_reject_next = multi_rise;
               end else begin
                  coin_reject_next = 1'b1;
               end
            end
         end
         CHANGE: begin
            change_out_next   = credit_reg;
            change_valid_next = (credit_reg != 10'd0);
            credit_next       = 10'd0;
            coin_reject_next  = any_rise;
         end
         default: begin
            credit_next = 10'd0;
         end
      endcase
      // moneyin is forced to 0 whenever the next state is CHANGE so the
      // dispenser never sees leftover credit it could vend against again.
      moneyin_next = (state_next == ACCUM) ? credit_next : 10'd0;
   end

   // Registered datapath: credit, outputs and coin edge history.
   always_ff @(posedge clk) begin
      if (!rst) begin
         credit_reg       <= 10'd0;
         moneyin_reg      <= 10'd0;
         change_out_reg   <= 10'd0;
         change_valid_reg <= 1'b0;
         coin_reject_reg  <= 1'b0;
         coin_prev_reg    <= 4'd0;
         first_reg        <= 1'b1;
      end else begin
         credit_reg       <= credit_next;
         moneyin_reg      <= moneyin_next;
         change_out_reg   <= change_out_next;
         change_valid_reg <= change_valid_next;
         coin_reject_reg  <= coin_reject_next;
         coin_prev_reg    <= coin_lvl;
         first_reg        <= 1'b0;
      end
   end

   assign moneyin      = moneyin_reg;
   assign change_out   = change_out_reg;
   assign change_valid = change_valid_reg;
   assign coin_reject  = coin_reject_reg;

`ifdef COIN_AUDIT_EN
   logic [15:0] audit_revenue_reg;
   logic [7:0]  audit_vends_reg;
   logic [16:0] revenue_sum;

   assign revenue_sum = {1'b0, audit_revenue_reg} + {7'd0, vend_deduct};

   // Audit counters: add the amount really taken on each vend, clamp at max.
   always_ff @(posedge clk) begin
      if (!rst) begin
         audit_revenue_reg <= 16'd0;
         audit_vends_reg   <= 8'd0;
      end else if ((state_reg == ACCUM) && vend) begin
         audit_revenue_reg <= revenue_sum[16] ? 16'hFFFF : revenue_sum[15:0];
         if (audit_vends_reg != 8'hFF) begin
            audit_vends_reg <= audit_vends_reg + 8'd1;
         end
      end
   end

   assign audit_revenue = audit_revenue_reg;
   assign audit_vends   = audit_vends_reg;
`endif

endmodule

// File: tb/tb_coin_accumulator.sv
// -----------------------------------------------------------------------------
// tb_coin_accumulator
//   Directed scenarios with hand-computed expectations. Inputs are driven 1 ns
//   after each rising edge and outputs are sampled at the same point, so each
//   tick() shows the result of the edge just taken.
//   Build with +define+COIN_AUDIT_EN to include the audit counter scenario.
// -----------------------------------------------------------------------------
module tb_coin_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_nickel;
   logic       coin_dime;
   logic       coin_quarter;
   logic       coin_dollar;
   logic       cancel;
   logic       outbev1;
   logic       outbev2;
   logic       outbev3;
   logic [9:0] moneyin;
   logic [9:0] change_out;
   logic       change_valid;
   logic       coin_reject;
`ifdef COIN_AUDIT_EN
   logic [15:0] audit_revenue;
   logic [7:0]  audit_vends;
`endif

   int checks   = 0;
   int failures = 0;

   coin_accumulator dut (
      .clk          (clk),
      .rst          (rst),
      .coin_nickel  (coin_nickel),
      .coin_dime    (coin_dime),
      .coin_quarter (coin_quarter),
      .coin_dollar  (coin_dollar),
      .cancel       (cancel),
      .outbev1      (outbev1),
      .outbev2      (outbev2),
      .outbev3      (outbev3),
      .moneyin      (moneyin),
      .change_out   (change_out),
      .change_valid (change_valid),
      .coin_reject  (coin_reject)
`ifdef COIN_AUDIT_EN
      ,
      .audit_revenue(audit_revenue),
      .audit_vends  (audit_vends)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // which: 0 nickel, 1 dime, 2 quarter, 3 dollar. Pulse high one cycle.
   task automatic insert(input int which);
      case (which)
         0: coin_nickel  = 1'b1;
         1: coin_dime    = 1'b1;
         2: coin_quarter = 1'b1;
         default: coin_dollar = 1'b1;
      endcase
      tick();
      coin_nickel  = 1'b0;
      coin_dime    = 1'b0;
      coin_quarter = 1'b0;
      coin_dollar  = 1'b0;
      tick();
      $display("coin %0d inserted: moneyin=%0d reject_now=%0b", which, moneyin, coin_reject);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      coin_quarter = 1'b1;   // held high through reset, must not count
      tick();
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL reset_moneyin got=%0d exp=0", moneyin); end
      checks++; if (change_out !== 10'd0) begin failures++; $display("FAIL reset_change_out got=%0d exp=0", change_out); end
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL reset_change_valid got=%0b exp=0", change_valid); end
      checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL reset_coin_reject got=%0b exp=0", coin_reject); end
      rst = 1'b1;
      tick();
      coin_quarter = 1'b0;
      tick();
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL reset_held_coin got=%0d exp=0", moneyin); end
      $display("reset done: moneyin=%0d", moneyin);
   endtask

   task automatic test_quarters_vend1;
      int exp;
      for (int i = 0; i < 5; i++) begin
         insert(2);
         exp = 25 * (i + 1);
         checks++; if (moneyin !== 10'(exp)) begin failures++; $display("FAIL quarter_accum got=%0d exp=%0d", moneyin, exp); end
      end
      outbev1 = 1'b1;
      tick();
      outbev1 = 1'b0;
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL vend1_moneyin got=%0d exp=0", moneyin); end
      tick();
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL vend1_no_change got=%0b exp=0", change_valid); end
      checks++; if (change_out !== 10'd0) begin failures++; $display("FAIL vend1_change_out got=%0d exp=0", change_out); end
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL vend1_moneyin_after got=%0d exp=0", moneyin); end
      tick();
      $display("vend1 exact credit: change_valid=%0b moneyin=%0d", change_valid, moneyin);
   endtask

   task automatic test_vend3_change;
      insert(3); insert(3); insert(2);
      checks++; if (moneyin !== 10'd225) begin failures++; $display("FAIL credit225 got=%0d exp=225", moneyin); end
      outbev3 = 1'b1;
      tick();
      outbev3 = 1'b0;
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL vend3_moneyin got=%0d exp=0", moneyin); end
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL vend3_early_valid got=%0b exp=0", change_valid); end
      tick();
      checks++; if (change_valid !== 1'b1) begin failures++; $display("FAIL vend3_valid got=%0b exp=1", change_valid); end
      checks++; if (change_out !== 10'd50) begin failures++; $display("FAIL vend3_change got=%0d exp=50", change_out); end
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL vend3_moneyin2 got=%0d exp=0", moneyin); end
      tick();
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL vend3_pulse got=%0b exp=0", change_valid); end
      $display("vend3: change 50 paid");
      // outbev1 wins over outbev2: 225 - 125 = 100 change
      insert(3); insert(3); insert(2);
      outbev1 = 1'b1; outbev2 = 1'b1;
      tick();
      outbev1 = 1'b0; outbev2 = 1'b0;
      tick();
      checks++; if (change_out !== 10'd100) begin failures++; $display("FAIL vend_priority got=%0d exp=100", change_out); end
      checks++; if (change_valid !== 1'b1) begin failures++; $display("FAIL vend_priority_valid got=%0b exp=1", change_valid); end
      tick();
      $display("vend priority: change_out=%0d", change_out);
   endtask

   task automatic test_max_reject_cancel;
      for (int i = 0; i < 5; i++) insert(3);
      checks++; if (moneyin !== 10'd500) begin failures++; $display("FAIL credit500 got=%0d exp=500", moneyin); end
      coin_nickel = 1'b1;
      tick();
      coin_nickel = 1'b0;
      checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL max_reject got=%0b exp=1", coin_reject); end
      checks++; if (moneyin !== 10'd500) begin failures++; $display("FAIL max_hold got=%0d exp=500", moneyin); end
      tick();
      checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL max_reject_pulse got=%0b exp=0", coin_reject); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL cancel_moneyin got=%0d exp=0", moneyin); end
      tick();
      checks++; if (change_valid !== 1'b1) begin failures++; $display("FAIL cancel_valid got=%0b exp=1", change_valid); end
      checks++; if (change_out !== 10'd500) begin failures++; $display("FAIL cancel_change got=%0d exp=500", change_out); end
      tick();
      $display("max credit reject then cancel refund 500");
   endtask

   task automatic test_cancel_idle;
      // cancel with no credit is ignored, so a coin on the same edge counts
      cancel = 1'b1; coin_nickel = 1'b1;
      tick();
      cancel = 1'b0; coin_nickel = 1'b0;
      checks++; if (moneyin !== 10'd5) begin failures++; $display("FAIL cancel_idle_coin got=%0d exp=5", moneyin); end
      checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL cancel_idle_reject got=%0b exp=0", coin_reject); end
      tick();
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL cancel_idle_valid got=%0b exp=0", change_valid); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
      checks++; if (change_out !== 10'd5) begin failures++; $display("FAIL cancel5_change got=%0d exp=5", change_out); end
      tick();
      $display("idle cancel ignored, refund 5");
   endtask

   task automatic test_simultaneous;
      coin_dime = 1'b1; coin_quarter = 1'b1;
      tick();
      coin_dime = 1'b0; coin_quarter = 1'b0;
      checks++; if (moneyin !== 10'd25) begin failures++; $display("FAIL simul_moneyin got=%0d exp=25", moneyin); end
      checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL simul_reject got=%0b exp=1", coin_reject); end
      tick();
      checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL simul_reject_pulse got=%0b exp=0", coin_reject); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
      checks++; if (change_out !== 10'd25) begin failures++; $display("FAIL simul_refund got=%0d exp=25", change_out); end
      tick();
      $display("dime+quarter together: quarter kept, dime rejected");
   endtask

   task automatic test_vend_coin_same_edge;
      insert(3); insert(2);
      outbev1 = 1'b1; coin_dollar = 1'b1;
      tick();
      outbev1 = 1'b0; coin_dollar = 1'b0;
      checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL vendcoin_reject got=%0b exp=1", coin_reject); end
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL vendcoin_moneyin got=%0d exp=0", moneyin); end
      tick();
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL vendcoin_valid got=%0b exp=0", change_valid); end
      tick();
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL vendcoin_credit got=%0d exp=0", moneyin); end
      // dime held for 10 cycles counts only once
      coin_dime = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      coin_dime = 1'b0;
      tick();
      checks++; if (moneyin !== 10'd10) begin failures++; $display("FAIL held_once got=%0d exp=10", moneyin); end
      $display("vend+coin rejected; held dime counted once: moneyin=%0d", moneyin);
   endtask

   task automatic test_back_to_back_reset;
      // clear the 10 from the previous scenario
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
      checks++; if (change_out !== 10'd10) begin failures++; $display("FAIL refund10 got=%0d exp=10", change_out); end
      tick();
      insert(3);
      checks++; if (moneyin !== 10'd100) begin failures++; $display("FAIL credit100 got=%0d exp=100", moneyin); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL midreset_moneyin got=%0d exp=0", moneyin); end
      tick();
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%0b exp=0", change_valid); end
      tick();
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL midreset_lost got=%0d exp=0", moneyin); end
      // reset while in CHANGE aborts the refund
      insert(3);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL change_abort got=%0b exp=0", change_valid); end
      tick();
      checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL change_abort2 got=%0b exp=0", change_valid); end
      checks++; if (moneyin !== 10'd0) begin failures++; $display("FAIL change_abort_credit got=%0d exp=0", moneyin); end
      $display("reset with credit and reset in CHANGE: credit dropped");
   endtask

`ifdef COIN_AUDIT_EN
   task automatic test_audit;
      checks++; if (audit_revenue !== 16'd0) begin failures++; $display("FAIL audit_rev_reset got=%0d exp=0", audit_revenue); end
      checks++; if (audit_vends !== 8'd0) begin failures++; $display("FAIL audit_vends_reset got=%0d exp=0", audit_vends); end
      for (int i = 0; i < 3; i++) begin
         insert(3); insert(3);
         outbev3 = 1'b1;
         tick();
         outbev3 = 1'b0;
         tick(); tick();
      end
      checks++; if (audit_revenue !== 16'd525) begin failures++; $display("FAIL audit_rev got=%0d exp=525", audit_revenue); end
      checks++; if (audit_vends !== 8'd3) begin failures++; $display("FAIL audit_vends got=%0d exp=3", audit_vends); end
      // saturated deduction: 100 credit, cost 220 -> only 100 counted
      insert(3);
      outbev2 = 1'b1;
      tick();
      outbev2 = 1'b0;
      tick(); tick();
      checks++; if (audit_revenue !== 16'd625) begin failures++; $display("FAIL audit_rev_sat got=%0d exp=625", audit_revenue); end
      checks++; if (audit_vends !== 8'd4) begin failures++; $display("FAIL audit_vends4 got=%0d exp=4", audit_vends); end
      $display("audit: revenue=%0d vends=%0d", audit_revenue, audit_vends);
   endtask
`endif

   initial begin
      rst = 1'b0;
      coin_nickel = 1'b0; coin_dime = 1'b0; coin_quarter = 1'b0; coin_dollar = 1'b0;
      cancel = 1'b0; outbev1 = 1'b0; outbev2 = 1'b0; outbev3 = 1'b0;
      test_reset();
      test_quarters_vend1();
      test_vend3_change();
      test_max_reject_cancel();
      test_cancel_idle();
      test_simultaneous();
      test_vend_coin_same_edge();
      test_back_to_back_reset();
`ifdef COIN_AUDIT_EN
      test_audit();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
- Upstream credit stage for the vending machine beverage dispenser.
- Detects coin insertions, accumulates credit, and drives the 10-bit `moneyin` credit bus into the dispenser.
- Watches the dispenser's one-cycle `outbev1..3` pulses, deducts the vended beverage's cost, and returns remaining credit as change.
- Also handles a customer cancel/refund request.

Parameters:
- BEV1_COST, 125, cost deducted on outbev1 (must match dispenser).
- BEV2_COST, 220, cost deducted on outbev2.
- BEV3_COST, 175, cost deducted on outbev3.
- MAX_CREDIT, 500, highest credit accepted; any coin that would exceed it is rejected.
- NICKEL_VAL / DIME_VAL / QUARTER_VAL / DOLLAR_VAL, 5 / 10 / 25 / 100, coin values.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- coin_nickel  input  1  coin sensor, level; accepted on its 0->1 transition.
- coin_dime  input  1  as above.
- coin_quarter  input  1  as above.
- coin_dollar  input  1  as above.
- cancel  input  1  refund request, level-sampled.
- outbev1  input  1  dispenser vend pulse, beverage 1.
- outbev2  input  1  dispenser vend pulse, beverage 2.
- outbev3  input  1  dispenser vend pulse, beverage 3.
- moneyin  output  10  credit presented to dispenser.
- change_out  output  10  change amount; valid only while change_valid = 1.
- change_valid  output  1  one-cycle pulse: pay change_out.
- coin_reject  output  1  one-cycle pulse: return the just-inserted coin.

Behaviour:
- Reset (rst = 0 at posedge):
  - credit = 0, state = ACCUM, coin edge registers = 0.
  - moneyin = 0, change_out = 0, change_valid = 0, coin_reject = 0.
- Coin edge detect:
  - Previous coin levels are registered; a coin counts as a rise when its current level is 1 and its registered previous level is 0.
  - A coin held high counts once.
  - On the first cycle after reset, a coin that is already high does not count as a rise.
- moneyin is registered and equals credit while state = ACCUM; it is 0 in CHANGE. This stops the dispenser re-vending on leftover credit.
- State ACCUM, evaluated each posedge in this priority order:
  1. Vend: any outbev = 1.
     - Priority outbev1 > outbev2 > outbev3, matching the dispenser.
     - credit <= credit - cost, saturating at 0 (no underflow wrap).
     - Next state CHANGE.
     - Any coin rise this cycle: coin_reject = 1, no credit added.
  2. Cancel: cancel = 1 and credit > 0.
     - Next state CHANGE with credit unchanged (full refund).
     - Any coin rise this cycle is rejected.
     - cancel = 1 with credit = 0 is ignored.
  3. Coin: one or more coin rises.
     - Accept the highest-value rising coin only (dollar > quarter > dime > nickel).
     - If credit + value <= MAX_CREDIT: credit += value. Otherwise credit is unchanged and coin_reject = 1.
     - Any additional simultaneous rises also set coin_reject = 1 (single pulse total).
     - Use 11-bit intermediate sum for the compare.
- State CHANGE (always exactly one cycle):
  - change_out <= credit; change_valid <= 1 only if credit > 0; credit <= 0; next state ACCUM.
  - Coin rises in CHANGE are rejected; outbev and cancel are ignored.
- Latency:
  - Coin rise sampled at edge k -> moneyin updated after edge k.
  - Vend pulse sampled at edge k -> moneyin = 0 after edge k; change_valid high for the cycle after edge k+1; moneyin = 0 after k+1.
- Outputs change_valid and coin_reject are pulses: cleared the cycle after they are set unless re-triggered.
- Reset in CHANGE aborts the pending change: change_valid stays 0 and credit is lost.

Optional Feature:
- Macro: COIN_AUDIT_EN.
- Defined:
  - Adds output ports `audit_revenue` [15:0] and `audit_vends` [7:0], both reset to 0.
  - On each vend (ACCUM, case 1), audit_revenue += the actual amount deducted (cost, or prior credit if it saturated); audit_vends += 1.
  - Both counters saturate at all-ones; no wrap.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then quarter rise x5 (separate pulses) -> moneyin = 125; then outbev1 pulse -> moneyin 0 next cycle, change_valid pulse with change_out = 0 suppressed (valid stays 0), credit 0.
- Dollar x2, quarter x1 (credit 225); outbev3 pulse -> change_valid = 1, change_out = 50 one cycle later, moneyin = 0 throughout the vend sequence.
- Dollar x5 (credit 500), then nickel rise -> coin_reject pulse, moneyin stays 500; cancel = 1 -> change_out = 500 with change_valid, moneyin 0.
- Dime and quarter rising same cycle from credit 0 -> moneyin = 25, coin_reject = 1 for one cycle.
- Credit 125: outbev1 and a dollar rise on the same edge -> coin_reject = 1, credit -> 0, change_valid stays 0. Also: coin held high for 10 cycles -> counted once.
- Credit 100, rst = 0 for one cycle with coins idle -> moneyin = 0, change_valid never pulses. With COIN_AUDIT_EN: three 175 vends -> audit_revenue = 525, audit_vends = 3.
